// File: rtl/isqrt32_iter_if.sv
// Bundles the operand and result of the iterative square-root block.
//
// Signals:
//   x    32-bit unsigned radicand, driven by the producer
//   y    16-bit root, floor(sqrt(x)); meaningful only while rdy is high
//   rdy  completion level; stays high until the block restarts
//
// Modports:
//   master  drives x, observes y and rdy (testbench / consumer side)
//   slave   observes x, drives y and rdy (the arithmetic block)
interface isqrt32_iter_if;
  logic [31:0] x;
  logic [15:0] y;
  logic        rdy;

  modport master (output x, input y, input rdy);
  modport slave  (input x, output y, output rdy);
endinterface

// File: rtl/isqrt32_iter.sv
// Bit-serial 32-bit unsigned integer square root, y = floor(sqrt(x)).
// One result bit is resolved per clock, MSB first. The block starts on
// its own when reset is released and raises rdy as a level once the root
// is final (18 rising edges after reset deasserts).
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears all state and holds the block idle
//   bus    isqrt32_iter_if.slave: x in, y and rdy out
//
// Configuration macro:
//   ISQRT32_AUTORESTART_EN  when defined, a change of x while in DONE sends
//                           the block back to LOAD and a fresh root is
//                           computed. When undefined, DONE is terminal
//                           until reset.
module isqrt32_iter (
  input  logic           clk,
  input  logic           reset,
  isqrt32_iter_if.slave  bus
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] xr_q;
  logic [15:0] acc;
  logic [3:0]  idx_q;
  logic        rdy_q;

  logic [15:0] trial;
  logic [31:0] trialSq;
  logic [15:0] acc_d;
  logic        restart;

  // Trial root sets the bit under test on top of the bits already decided.
  // A 16-bit value squared always fits in 32 bits, so the compare is exact.
  always_comb begin
    trial   = acc | (16'h0001 << idx_q);
    trialSq = 32'(trial) * 32'(trial);
    acc_d   = (trialSq <= xr_q) ? trial : acc;
`ifdef ISQRT32_AUTORESTART_EN
    restart = (bus.x != xr_q);
`else
    restart = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD;
      xr_q    <= 32'd0;
      acc     <= 16'd0;
      idx_q   <= 4'd15;
      rdy_q   <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          xr_q    <= bus.x;
          acc     <= 16'd0;
          idx_q   <= 4'd15;
          rdy_q   <= 1'b0;
          state_q <= CALC;
        end
        CALC: begin
          acc   <= acc_d;
          idx_q <= idx_q - 4'd1;
          // Bit 0 is the last decision; idx wraps harmlessly afterwards.
          if (idx_q == 4'd0) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (restart) begin
            rdy_q   <= 1'b0;
            state_q <= LOAD;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

  // y shows the partial root while computing; consumers qualify with rdy.
  assign bus.y   = acc;
  assign bus.rdy = rdy_q;

endmodule

// File: tb/tb_isqrt32_iter.sv
// Self-checking bench for isqrt32_iter. Stimulus pushes the hand-computed
// root and the cycle at which rdy must rise into a scoreboard; a monitor
// pops and compares on every rising edge of rdy.
module tb_isqrt32_iter;

  typedef struct {
    logic [15:0] expY;
    int          expCyc;
    string       name;
  } expT;

  logic clk;
  logic reset;
  int   cyc;
  int   checkCount;
  int   passCount;
  logic prevRdy;
  expT  sb[$];
  logic [15:0] trace63 [1:17];

  isqrt32_iter_if bus ();

  isqrt32_iter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount = checkCount + 1;
    if (actual === expected) begin
      passCount = passCount + 1;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every rising rdy must match the oldest scoreboard entry,
  // both in value and in the cycle it arrives on.
  initial begin
    prevRdy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rdy === 1'b1 && prevRdy !== 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rdy", 32'(bus.y), 32'hFFFFFFFF);
        end else begin
          expT e;
          e = sb.pop_front();
          checkOutput({e.name, "_y"}, 32'(bus.y), 32'(e.expY));
          checkOutput({e.name, "_latency"}, 32'(cyc), 32'(e.expCyc));
        end
      end
      prevRdy = bus.rdy;
    end
  end

  task automatic waitDrained(input string name);
    int i;
    i = 0;
    while (sb.size() != 0 && i < 40) begin
      @(negedge clk);
      i = i + 1;
    end
    if (sb.size() != 0) begin
      checkOutput({name, "_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic applyStimulus(input logic [31:0] xVal, input logic [15:0] expY,
                               input string name);
    reset = 1'b1;
    bus.x = xVal;
    repeat (3) @(negedge clk);
    sb.push_back('{expY, cyc + 18, name});
    reset = 1'b0;
    waitDrained(name);
    repeat (3) @(negedge clk);
    checkOutput({name, "_hold_rdy"}, 32'(bus.rdy), 32'd1);
    checkOutput({name, "_hold_y"}, 32'(bus.y), 32'(expY));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    passCount  = 0;
    for (int k = 1; k <= 17; k++) trace63[k] = 16'd0;
    trace63[15] = 16'd4;
    trace63[16] = 16'd6;
    trace63[17] = 16'd7;

    // Reset held 100 time units with x=63, then trace acc edge by edge.
    reset = 1'b1;
    bus.x = 32'd63;
    repeat (10) @(negedge clk);
    checkOutput("reset_rdy", 32'(bus.rdy), 32'd0);
    checkOutput("reset_y", 32'(bus.y), 32'd0);
    checkOutput("reset_acc", 32'(dut.acc), 32'd0);
    sb.push_back('{16'd7, cyc + 18, "x63"});
    reset = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      checkOutput($sformatf("x63_acc_edge%0d", k), 32'(dut.acc), 32'(trace63[k]));
    end
    waitDrained("x63");

    applyStimulus(32'd0,          16'd0,     "x0");
    applyStimulus(32'hFFFFFFFF,   16'd65535, "xmax");
    applyStimulus(32'hFFFE0001,   16'd65535, "x65535sq");
    applyStimulus(32'hFFFE0000,   16'd65534, "x65535sq_m1");
    applyStimulus(32'd64,         16'd8,     "x64");
    applyStimulus(32'd1,          16'd1,     "x1");
    applyStimulus(32'd2,          16'd1,     "x2");
    applyStimulus(32'd1000000,    16'd1000,  "x1e6");

    // Reset mid-run after edge 8, then restart with x=144.
    reset = 1'b1;
    bus.x = 32'd63;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("midreset_rdy", 32'(bus.rdy), 32'd0);
    checkOutput("midreset_acc", 32'(dut.acc), 32'd0);
    checkOutput("midreset_y", 32'(bus.y), 32'd0);
    bus.x = 32'd144;
    @(negedge clk);
    sb.push_back('{16'd12, cyc + 18, "x144"});
    reset = 1'b0;
    waitDrained("x144");
    @(negedge clk);
    checkOutput("x144_hold_y", 32'(bus.y), 32'd12);

    // Changing x after completion.
    applyStimulus(32'd63, 16'd7, "x63b");
    bus.x = 32'd100;
`ifdef ISQRT32_AUTORESTART_EN
    sb.push_back('{16'd10, cyc + 19, "autorestart"});
    @(negedge clk);
    checkOutput("autorestart_rdy_fall", 32'(bus.rdy), 32'd0);
    waitDrained("autorestart");
    @(negedge clk);
    checkOutput("autorestart_hold_y", 32'(bus.y), 32'd10);
`else
    repeat (25) @(negedge clk);
    checkOutput("noautorestart_rdy", 32'(bus.rdy), 32'd1);
    checkOutput("noautorestart_y", 32'(bus.y), 32'd7);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
